avalon_msg_generator: RTL

- Avalon-ST source that turns one length/seed request into a single well-formed packet: sop on the first beat, eop on the last beat, correct empty, and a deterministic incrementing byte pattern.
- It is the transmit end of the same avalon_st_if stream that avalon_enforcer receives.
- Used as a legal traffic source in front of the enforcer and other stream blocks, and as a reference transmitter for later framing logic.

---
 rtl/avalon_gen_pkg.sv | 38 +++
 rtl/avalon_st_if.sv | 40 ++++
 rtl/avalon_pattern_beat.sv | 21 ++
 rtl/avalon_msg_generator.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/avalon_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_gen_pkg
//  Description : Shared types and length arithmetic for the Avalon-ST
//                message generator and its companion pattern checkers.
//  Revision    : 1.0 - initial release
// ============================================================================
package avalon_gen_pkg;

    // Generator control state; explicit 1-bit encoding.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } gen_state_t;

    // Number of W-byte beats needed to carry len bytes, i.e. ceil(len / w).
    // The sum is formed one bit wider than len so the largest length cannot
    // wrap before the divide. w is a power of two, so the divide reduces to
    // a shift once the caller's constant w is folded in.
    // len is zero-extended by the caller; lengths up to 32 bits are covered.
    function automatic logic [31:0] beats_for_len(input logic [31:0]  len,
                                                  input int unsigned  w);
        logic [32:0] l_sum;
        l_sum = {1'b0, len} + {1'b0, w - 32'd1};
        return 32'(l_sum / {1'b0, w});
    endfunction

    // Unused byte lanes on the final beat: (w - (len mod w)) mod w.
    // Only the low log2(w) bits of len influence the result.
    function automatic logic [31:0] empty_for_len(input logic [31:0] len,
                                                  input int unsigned w);
        logic [31:0] l_rem;
        l_rem = len % w;
        return (w - l_rem) % w;
    endfunction

endpackage : avalon_gen_pkg
`default_nettype wire

// File: rtl/avalon_st_if.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_st_if
//  Description : Avalon-ST packet stream bundle (data, valid, sop, eop,
//                empty, rdy). Symbol 0 sits in the most significant byte.
//  Revision    : 1.0 - initial release
// ============================================================================
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
) ();

    localparam int c_EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [c_EMPTY_W-1:0]             empty;
    logic                             rdy;

    modport master (
        output data,
        output valid,
        output sop,
        output eop,
        output empty,
        input  rdy
    );

    modport slave (
        input  data,
        input  valid,
        input  sop,
        input  eop,
        input  empty,
        output rdy
    );

endinterface : avalon_st_if
`default_nettype wire

// File: rtl/avalon_pattern_beat.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_pattern_beat
//  Description : Combinational incrementing-byte beat builder. Byte i of the
//                word (byte 0 in the top 8 bits) equals byte_base + i mod 256.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_pattern_beat #(
    parameter int DATA_WIDTH_IN_BYTES = 16
) (
    input  logic [7:0]                       byte_base,
    output logic [8*DATA_WIDTH_IN_BYTES-1:0] data
);

    // One adder per lane; lane i lands MSB-first in the output word.
    for (genvar i = 0; i < DATA_WIDTH_IN_BYTES; i++) begin : g_byte
        assign data[8*(DATA_WIDTH_IN_BYTES-i)-1 -: 8] = byte_base + 8'(i);
    end

endmodule : avalon_pattern_beat
`default_nettype wire

// File: rtl/avalon_msg_generator.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_msg_generator
//  Description : Avalon-ST source that turns one length/seed request into a
//                single framed packet (sop/eop/empty) carrying an
//                incrementing byte pattern that starts at the seed.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_msg_generator
    import avalon_gen_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int LEN_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_rdy,
    input  logic [LEN_WIDTH-1:0] req_len,
    input  logic [7:0]           req_seed,
    avalon_st_if.master          msg_out,
    output logic                 zero_len_indi,
    output logic                 pkt_done
);

    localparam int unsigned c_W       = DATA_WIDTH_IN_BYTES;
    localparam int          c_EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);
    localparam int          c_DATA_W  = 8 * DATA_WIDTH_IN_BYTES;
    localparam logic [7:0]  c_BASE_INC = 8'(c_W);
    localparam logic [LEN_WIDTH-1:0] c_ONE_BEAT  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] c_TWO_BEATS = LEN_WIDTH'(2);

    // Control state and packet bookkeeping.
    gen_state_t             r_state;
    logic [LEN_WIDTH-1:0]   r_beats_left;
    logic [7:0]             r_byte_base;
    logic [c_EMPTY_W-1:0]   r_empty_last;

    // Registered stream and side-band outputs.
    logic                   r_req_rdy;
    logic                   r_valid;
    logic                   r_sop;
    logic                   r_eop;
    logic [c_EMPTY_W-1:0]   r_empty;
    logic [c_DATA_W-1:0]    r_data;
    logic                   r_zero_len;
    logic                   r_pkt_done;

    // Next-beat helpers.
    logic [LEN_WIDTH-1:0]   w_beats;
    logic [c_EMPTY_W-1:0]   w_empty;
    logic [7:0]             w_next_base;
    logic [c_DATA_W-1:0]    w_pattern;
    logic                   w_xfer;

    // Length arithmetic on the live request; only used on the accept edge.
    assign w_beats = LEN_WIDTH'(beats_for_len(32'(req_len), c_W));
    assign w_empty = c_EMPTY_W'(empty_for_len(32'(req_len), c_W));

    // In IDLE the next beat starts at the seed; in SEND it is the beat after
    // the one currently presented.
    assign w_next_base = (r_state == IDLE) ? req_seed : (r_byte_base + c_BASE_INC);

    assign w_xfer = r_valid && msg_out.rdy;

    avalon_pattern_beat #(
        .DATA_WIDTH_IN_BYTES (DATA_WIDTH_IN_BYTES)
    ) u_pattern (
        .byte_base (w_next_base),
        .data      (w_pattern)
    );

    // Request acceptance, beat sequencing and framing, all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beats_left <= '0;
            r_byte_base  <= '0;
            r_empty_last <= '0;
            r_req_rdy    <= 1'b1;
            r_valid      <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_empty      <= '0;
            r_data       <= '0;
            r_zero_len   <= 1'b0;
            r_pkt_done   <= 1'b0;
        end else begin
            r_zero_len <= 1'b0;
            r_pkt_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_len == '0) begin
                            // Nothing to send: flag it and stay ready.
                            r_zero_len <= 1'b1;
                        end else begin
                            r_state      <= SEND;
                            r_req_rdy    <= 1'b0;
                            r_beats_left <= w_beats;
                            r_byte_base  <= req_seed;
                            r_empty_last <= w_empty;
                            r_data       <= w_pattern;
                            r_valid      <= 1'b1;
                            r_sop        <= 1'b1;
                            r_eop        <= (w_beats == c_ONE_BEAT);
                            r_empty      <= (w_beats == c_ONE_BEAT) ? w_empty : '0;
                        end
                    end
                end

                SEND: begin
                    if (w_xfer) begin
                        if (r_eop) begin
                            // Final beat taken: close the packet.
                            r_state      <= IDLE;
                            r_req_rdy    <= 1'b1;
                            r_valid      <= 1'b0;
                            r_sop        <= 1'b0;
                            r_eop        <= 1'b0;
                            r_empty      <= '0;
                            r_beats_left <= '0;
                            r_pkt_done   <= 1'b1;
                        end else begin
                            r_beats_left <= r_beats_left - c_ONE_BEAT;
                            r_byte_base  <= w_next_base;
                            r_data       <= w_pattern;
                            r_sop        <= 1'b0;
                            r_eop        <= (r_beats_left == c_TWO_BEATS);
                            r_empty      <= (r_beats_left == c_TWO_BEATS) ? r_empty_last : '0;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_rdy       = r_req_rdy;
    assign msg_out.valid = r_valid;
    assign msg_out.sop   = r_sop;
    assign msg_out.eop   = r_eop;
    assign msg_out.empty = r_empty;
    assign msg_out.data  = r_data;
    assign zero_len_indi = r_zero_len;
    assign pkt_done      = r_pkt_done;

endmodule : avalon_msg_generator
`default_nettype wire
